// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounced push-buttons with auto-repeat, arbitrated round-robin onto one valid/ready event port
module button_event_arbiter #(
    parameter int N_BTN        = 4,
    parameter int DB_CYCLES    = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_id,
    output logic                     ev_repeat,
    output logic [N_BTN-1:0]         held,
    output logic                     overrun
);
    localparam int ID_W = $clog2(N_BTN);
    logic [N_BTN-1:0] sync1, sync2, stable, stable_q, rep_phase, rise, fire;
    logic [N_BTN-1:0] pending, pend_rep, clr, acc;
    logic [CNT_W-1:0] db_cnt [N_BTN];
    logic [CNT_W-1:0] hold_timer [N_BTN];
    logic [ID_W-1:0]  rr, winner;
    logic             found, load, take;

    assign held = stable;
    assign rise = stable & ~stable_q;

    // repeat fires when the hold timer reaches the current period (first delay, then rate)
    always_comb begin
        fire = '0;
        for (int i = 0; i < N_BTN; i++)
            fire[i] = stable[i] & stable_q[i] &
                      (hold_timer[i] == (rep_phase[i] ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1)));
    end

    // synchroniser, debouncer and hold timer for every button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            stable_q  <= '0;
            rep_phase <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i]     <= '0;
                hold_timer[i] <= '0;
            end
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                if (!stable[i] || rise[i]) begin
                    hold_timer[i] <= '0;
                    rep_phase[i]  <= 1'b0;
                end else if (fire[i]) begin
                    hold_timer[i] <= '0;
                    rep_phase[i]  <= 1'b1;
                end else begin
                    hold_timer[i] <= hold_timer[i] + 1'b1;
                end
            end
        end
    end

    // round-robin pick of the first pending button at or after rr; acc marks posts that are accepted
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!found && pending[ID_W'((int'(rr) + k) % N_BTN)]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr) + k) % N_BTN);
            end
        end
        load = !ev_valid || ev_ready;
        take = load && found;
        clr  = take ? (N_BTN'(1) << winner) : '0;
        acc  = (rise | fire) & ~(pending & ~clr);
    end

    // pending bookkeeping, sticky overrun and the output event register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            pend_rep  <= '0;
            overrun   <= 1'b0;
            rr        <= '0;
            ev_valid  <= 1'b0;
            ev_id     <= '0;
            ev_repeat <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | acc;
            pend_rep <= (acc & fire) | (~acc & pend_rep);
            if (|((rise | fire) & ~acc))
                overrun <= 1'b1;
            if (load)
                ev_valid <= found;
            if (take) begin
                ev_id     <= winner;
                ev_repeat <= pend_rep[winner];
                rr        <= (winner == ID_W'(N_BTN - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
endmodule
